// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812/SK6812 frame controller: FSM state codes,
// default 100 MHz bit timing, byte-order selectors and the counter-width helper.
package ws2812_pkg;

  typedef logic [2:0] ws_state_t;

  localparam ws_state_t ST_IDLE   = 3'd0;
  localparam ws_state_t ST_FETCH  = 3'd1;
  localparam ws_state_t ST_WAIT_Q = 3'd2;
  localparam ws_state_t ST_BIT_HI = 3'd3;
  localparam ws_state_t ST_BIT_LO = 3'd4;
  localparam ws_state_t ST_LATCH  = 3'd5;
  localparam ws_state_t ST_DONE   = 3'd6;

  localparam int DEF_T0H  = 40;
  localparam int DEF_T1H  = 80;
  localparam int DEF_TBIT = 125;
  localparam int DEF_TRST = 8000;

  localparam int BPL_GRB  = 3;
  localparam int BPL_GRBW = 4;

  // One counter serves both the bit period and the latch code.
  function automatic int ws_cnt_width(input int trst, input int tbit);
    return $clog2(((trst > tbit) ? trst : tbit) + 1);
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_ram.sv
// Single-clock colour table: one write port, one registered read port,
// read-old-data on a same-address collision.
module ws2812_tdp_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, wa} < (AW+1)'(DEPTH))) mem[wa] <= wd;
    q <= mem[ra];
  end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812/SK6812 frame controller: colour table plus one-pin serialiser and latch code.
// Optional per-frame brightness scaling is enabled with `define WS2812_BRIGHTNESS_EN.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int LED_NUM       = 16,
  parameter int BYTES_PER_LED = BPL_GRB,
  parameter int T0H           = DEF_T0H,
  parameter int T1H           = DEF_T1H,
  parameter int TBIT          = DEF_TBIT,
  parameter int TRST          = DEF_TRST,
  parameter int ADDR_BIT      = $clog2(LED_NUM),
  parameter int W             = 8 * BYTES_PER_LED
) (
  input  logic                clk100,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_BIT-1:0] wr_addr,
  input  logic [W-1:0]        wr_data,
  input  logic [ADDR_BIT:0]   frame_len,
  input  logic                update_request,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]          bright,
`endif
  output logic                busy,
  output logic                update_done,
  output logic                DOUT,
  output logic                RST
);

  if (BYTES_PER_LED != BPL_GRB && BYTES_PER_LED != BPL_GRBW) begin : g_bpl_check
    $error("BYTES_PER_LED must be 3 (GRB) or 4 (GRBW)");
  end
  if (!(T0H < T1H && T1H < TBIT)) begin : g_timing_check
    $error("bit timing must satisfy T0H < T1H < TBIT");
  end

`ifdef WS2812_BRIGHTNESS_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 2;
`endif
  localparam int CW = ws_cnt_width(TRST, TBIT);
  localparam int BW = $clog2(W);
  localparam int LW = ADDR_BIT + 1;

  ws_state_t           state, state_n;
  logic [CW-1:0]       cnt, cnt_n, hi_end, lo_end;
  logic [ADDR_BIT-1:0] idx, idx_n;
  logic [LW-1:0]       len, len_n;
  logic [BW-1:0]       bitcnt, bitcnt_n;
  logic [W-1:0]        shreg, shreg_n, q, load_word;
  logic                pending, pending_n, last_word, load_now;

  ws2812_tdp_ram #(.DEPTH(LED_NUM), .AW(ADDR_BIT), .DW(W)) u_ram (
    .clk (clk100),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (idx),
    .q   (q)
  );

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q, bright_n;
  logic       wq, wq_n;
  logic [W-1:0] scaled_p0;

  function automatic logic [W-1:0] scale_word(input logic [W-1:0] w, input logic [7:0] br);
    logic [W-1:0] r;
    logic [15:0]  p;
    r = '0;
    for (int b = 0; b < BYTES_PER_LED; b++) begin
      p = 16'(w[b*8 +: 8]) * (16'(br) + 16'd1);
      r[b*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

  // Scale stage: q settles in the first WAIT_Q cycle, the product is loaded in the second.
  always_ff @(posedge clk100) scaled_p0 <= scale_word(q, bright_q);

  assign load_word = scaled_p0;
`else
  assign load_word = q;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    len_n     = len;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    pending_n = pending;
    load_now  = 1'b1;
`ifdef WS2812_BRIGHTNESS_EN
    bright_n  = bright_q;
    wq_n      = 1'b0;
`endif
    last_word = ({1'b0, idx} + LW'(1)) >= len;
    hi_end    = shreg[W-1] ? CW'(T1H - 1) : CW'(T0H - 1);
    // The last bit of a non-final word absorbs the FETCH/WAIT_Q gap.
    lo_end    = (bitcnt == '0 && !last_word) ? CW'(TBIT - 1 - GAP) : CW'(TBIT - 1);

    case (state)
      ST_IDLE: begin
        if (update_request || pending) begin
          pending_n = 1'b0;
          idx_n     = '0;
          cnt_n     = '0;
          len_n     = (frame_len > LW'(LED_NUM)) ? LW'(LED_NUM) : frame_len;
          state_n   = (len_n == '0) ? ST_LATCH : ST_FETCH;
`ifdef WS2812_BRIGHTNESS_EN
          bright_n  = bright;
`endif
        end
      end
      ST_FETCH: state_n = ST_WAIT_Q;
      ST_WAIT_Q: begin
`ifdef WS2812_BRIGHTNESS_EN
        load_now = wq;
        wq_n     = ~wq;
`endif
        if (load_now) begin
          shreg_n  = load_word;
          bitcnt_n = BW'(W - 1);
          cnt_n    = '0;
          state_n  = ST_BIT_HI;
        end
      end
      ST_BIT_HI: begin
        cnt_n = cnt + CW'(1);
        if (cnt == hi_end) state_n = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (cnt == lo_end) begin
          cnt_n = '0;
          if (bitcnt != '0) begin
            shreg_n  = shreg << 1;
            bitcnt_n = bitcnt - BW'(1);
            state_n  = ST_BIT_HI;
          end else if (!last_word) begin
            idx_n   = idx + ADDR_BIT'(1);
            state_n = ST_FETCH;
          end else begin
            state_n = ST_LATCH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_LATCH: begin
        if (cnt == CW'(TRST - 1)) begin
          cnt_n   = '0;
          state_n = ST_DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Single-depth request queue; a pulse during DONE is kept too.
    if (update_request && state != ST_IDLE) pending_n = 1'b1;
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      len         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      DOUT        <= 1'b0;
      RST         <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
      bright_q    <= 8'hFF;
      wq          <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      len         <= len_n;
      bitcnt      <= bitcnt_n;
      shreg       <= shreg_n;
      pending     <= pending_n;
      busy        <= (state_n != ST_IDLE);
      update_done <= (state_n == ST_DONE);
      DOUT        <= (state_n == ST_BIT_HI);
      RST         <= (state_n == ST_LATCH);
`ifdef WS2812_BRIGHTNESS_EN
      bright_q    <= bright_n;
      wq          <= wq_n;
`endif
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: decodes DOUT pulse widths back into
// words and compares them with a shadow copy of the colour table.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;

  localparam int LED_NUM = 16;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int BPL = 4;
`else
  localparam int BPL = 3;
`endif
  localparam int W    = 8 * BPL;
  localparam int AB   = 4;
  localparam int T0H  = 4;
  localparam int T1H  = 9;
  localparam int TBIT = 14;
  localparam int TRST = 60;

  logic          clk100 = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AB:0]   frame_len = '0;
  logic          update_request = 1'b0;
  logic          busy, update_done, DOUT, RST;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]    bright = 8'hFF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] shadow [LED_NUM];
  int hi_q[$];
  int per_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = -1, rst_len = 0, rst_run = 0;
  int rst_fall_cyc = -2, last_rise = -1, hi_run = 0;
  logic prev_dout = 1'b0, prev_rst = 1'b0;

  always #5 clk100 = ~clk100;

  ws2812_frame_ctrl #(
    .LED_NUM(LED_NUM), .BYTES_PER_LED(BPL), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
  ) dut (
    .clk100         (clk100),
    .reset_n        (reset_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_len      (frame_len),
    .update_request (update_request),
`ifdef WS2812_BRIGHTNESS_EN
    .bright         (bright),
`endif
    .busy           (busy),
    .update_done    (update_done),
    .DOUT           (DOUT),
    .RST            (RST)
  );

  // Line monitor: high-pulse widths, rise-to-rise periods, latch length, done pulses.
  always @(negedge clk100) begin
    if (!reset_n) begin
      hi_run = 0; last_rise = -1; rst_run = 0; prev_dout = 1'b0; prev_rst = 1'b0;
    end else begin
      if (DOUT && !prev_dout) begin
        if (last_rise >= 0) per_q.push_back(cyc - last_rise);
        last_rise = cyc;
        hi_run = 0;
      end
      if (DOUT) hi_run++;
      if (!DOUT && prev_dout) hi_q.push_back(hi_run);
      if (RST) rst_run++;
      if (!RST && prev_rst) begin
        rst_len = rst_run; rst_run = 0; rst_fall_cyc = cyc; last_rise = -1;
      end
      if (update_done) begin done_cnt++; done_cyc = cyc; end
      prev_dout = DOUT;
      prev_rst  = RST;
    end
    cyc++;
  end

  function automatic logic [W-1:0] decode_word(input int i);
    logic [W-1:0] w = '0;
    for (int b = 0; b < W; b++) w = {w[W-2:0], (hi_q[i*W + b] == T1H)};
    return w;
  endfunction

  function automatic int bad_hi();
    int n = 0;
    foreach (hi_q[i]) if (hi_q[i] != T0H && hi_q[i] != T1H) n++;
    return n;
  endfunction

  function automatic int bad_per();
    int n = 0;
    foreach (per_q[i]) if (per_q[i] != TBIT) n++;
    return n;
  endfunction

  function automatic int frame_budget(input int n);
    return n * W * TBIT + TRST + 100;
  endfunction

  task automatic write_led(input int a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = AB'(a); wr_data = d;
    @(posedge clk100); #1;
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic pulse_req(input int n);
    frame_len = (AB+1)'(n); update_request = 1'b1;
    @(posedge clk100); #1;
    update_request = 1'b0;
  endtask

  task automatic clear_cap();
    hi_q.delete(); per_q.delete(); rst_len = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk100); #1;
      if (done_cnt > start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk100);
    @(negedge clk100);
    n_tests++; if (DOUT !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", DOUT); end
    n_tests++; if (RST !== 1'b0) begin n_fail++; $display("FAIL reset_rst: got %b want 0", RST); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", update_done); end
    @(posedge clk100); #1;
    reset_n = 1'b1;
    @(posedge clk100); #1;
  endtask

  task automatic test_single();
    logic [31:0] base = 32'hA50FF03C;
    logic [W-1:0] w = base[31 -: W];
    bit ok;
    write_led(0, w);
    clear_cap();
    pulse_req(1);
    @(negedge clk100);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done(frame_budget(1), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_done: no update_done within budget"); end
    n_tests++; if (hi_q.size() != W) begin n_fail++; $display("FAIL single_bits: got %0d want %0d", hi_q.size(), W); end
    n_tests++;
    if (hi_q.size() < 2 || hi_q[0] != T1H || hi_q[1] != T0H) begin
      n_fail++; $display("FAIL single_hi: first widths %0d,%0d want %0d,%0d",
                         hi_q.size() > 0 ? hi_q[0] : -1, hi_q.size() > 1 ? hi_q[1] : -1, T1H, T0H);
    end
    n_tests++;
    if (bad_per() != 0 || per_q.size() != W - 1) begin
      n_fail++; $display("FAIL single_period: bad %0d of %0d, want 0 of %0d", bad_per(), per_q.size(), W - 1);
    end
    n_tests++;
    if (hi_q.size() == W && decode_word(0) !== w) begin
      n_fail++; $display("FAIL single_word: got %h want %h", decode_word(0), w);
    end
    n_tests++; if (rst_len != TRST) begin n_fail++; $display("FAIL single_latch: got %0d want %0d", rst_len, TRST); end
    n_tests++; if (done_cyc != rst_fall_cyc) begin n_fail++; $display("FAIL single_done_pos: done at %0d, latch end %0d", done_cyc, rst_fall_cyc); end
    @(negedge clk100);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clr: got %b want 0", busy); end
    @(posedge clk100); #1;
  endtask

  task automatic test_random_frames();
    int lens[5];
    int n, errs;
    bit ok;
    for (int i = 0; i < LED_NUM; i++) write_led(i, W'({$urandom, $urandom}));
    lens = '{20, 0, 16, int'($urandom_range(1, 15)), int'($urandom_range(1, 15))};
    foreach (lens[k]) begin
      n = (lens[k] > LED_NUM) ? LED_NUM : lens[k];
      clear_cap();
      pulse_req(lens[k]);
      wait_done(frame_budget(n), ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_done len=%0d: no update_done", lens[k]); end
      errs = 0;
      if (hi_q.size() == n * W) for (int i = 0; i < n; i++) if (decode_word(i) !== shadow[i]) errs++;
      n_tests++;
      if (hi_q.size() != n * W || errs != 0 || bad_hi() != 0) begin
        n_fail++; $display("FAIL rand_frame len=%0d: bits %0d word_errs %0d, want bits %0d word_errs 0",
                           lens[k], hi_q.size(), errs, n * W);
      end
      n_tests++;
      if (bad_per() != 0 || per_q.size() != ((n > 0) ? n * W - 1 : 0)) begin
        n_fail++; $display("FAIL rand_period len=%0d: bad %0d of %0d", lens[k], bad_per(), per_q.size());
      end
      n_tests++; if (rst_len != TRST) begin n_fail++; $display("FAIL rand_latch len=%0d: got %0d want %0d", lens[k], rst_len, TRST); end
    end
  endtask

  task automatic test_back_to_back();
    int errs, d0;
    bit ok, ok2, reached;
    clear_cap();
    d0 = done_cnt;
    pulse_req(3);
    reached = 1'b0;
    for (int i = 0; i < frame_budget(3); i++) begin
      @(posedge clk100); #1;
      if (hi_q.size() >= 2 * W + 5) begin reached = 1'b1; break; end
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL b2b_reach: only %0d bits seen", hi_q.size()); end
    for (int p = 0; p < 3; p++) begin
      pulse_req(3);
      repeat (4) @(posedge clk100);
      #1;
    end
    wait_done(frame_budget(3), ok);
    @(posedge clk100); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: busy %b want 1", busy); end
    wait_done(frame_budget(3), ok2);
    n_tests++; if (!(ok && ok2)) begin n_fail++; $display("FAIL b2b_done: first %b second %b want 1 1", ok, ok2); end
    repeat (frame_budget(3)) @(posedge clk100);
    #1;
    errs = 0;
    if (hi_q.size() == 6 * W) for (int i = 0; i < 6; i++) if (decode_word(i) !== shadow[i % 3]) errs++;
    n_tests++;
    if (hi_q.size() != 6 * W || errs != 0) begin
      n_fail++; $display("FAIL b2b_frames: bits %0d word_errs %0d, want bits %0d word_errs 0", hi_q.size(), errs, 6 * W);
    end
    n_tests++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_count: %0d done pulses want 2", done_cnt - d0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b want 0", busy); end
  endtask

  task automatic test_request_at_done();
    bit seen, ok;
    clear_cap();
    pulse_req(1);
    seen = 1'b0;
    for (int i = 0; i < frame_budget(1); i++) begin
      @(negedge clk100);
      if (update_done === 1'b1) begin seen = 1'b1; break; end
    end
    update_request = 1'b1; frame_len = (AB+1)'(1);
    @(posedge clk100); #1;
    update_request = 1'b0;
    wait_done(frame_budget(1), ok);
    n_tests++;
    if (!(seen && ok) || hi_q.size() != 2 * W) begin
      n_fail++; $display("FAIL done_req: seen %b second %b bits %0d want 1 1 %0d", seen, ok, hi_q.size(), 2 * W);
    end
  endtask

  task automatic test_reset_mid();
    int d0, errs;
    bit hit, ok;
    clear_cap();
    pulse_req(2);
    hit = 1'b0;
    for (int i = 0; i < frame_budget(2); i++) begin
      @(negedge clk100);
      if (hi_q.size() >= 7 && DOUT === 1'b1) begin hit = 1'b1; break; end
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (!hit || DOUT !== 1'b0) begin n_fail++; $display("FAIL midrst_dout: hit %b dout %b want 1 0", hit, DOUT); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    d0 = done_cnt;
    repeat (3) @(posedge clk100);
    #1 reset_n = 1'b1;
    clear_cap();
    repeat (frame_budget(2)) @(posedge clk100);
    #1;
    n_tests++;
    if (done_cnt != d0 || hi_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_quiet: done pulses %0d bits %0d want 0 0", done_cnt - d0, hi_q.size());
    end
    pulse_req(2);
    wait_done(frame_budget(2), ok);
    errs = 0;
    if (hi_q.size() == 2 * W) for (int i = 0; i < 2; i++) if (decode_word(i) !== shadow[i]) errs++;
    n_tests++;
    if (!ok || hi_q.size() != 2 * W || errs != 0) begin
      n_fail++; $display("FAIL midrst_clean: done %b bits %0d word_errs %0d want 1 %0d 0", ok, hi_q.size(), errs, 2 * W);
    end
  endtask

  task automatic test_write_in_flight();
    logic [W-1:0] old1, new1;
    bit ok, reached;
    for (int i = 0; i < 3; i++) write_led(i, W'({$urandom, $urandom}));
    old1 = shadow[1];
    new1 = ~old1;
    clear_cap();
    pulse_req(3);
    reached = 1'b0;
    for (int i = 0; i < frame_budget(3); i++) begin
      @(posedge clk100); #1;
      if (hi_q.size() >= W + 3) begin reached = 1'b1; break; end
    end
    write_led(1, new1);
    wait_done(frame_budget(3), ok);
    n_tests++;
    if (!reached || !ok || hi_q.size() != 3 * W || decode_word(1) !== old1) begin
      n_fail++; $display("FAIL inflight_old: bits %0d led1 %h want %h", hi_q.size(),
                         (hi_q.size() >= 2 * W) ? decode_word(1) : '0, old1);
    end
    n_tests++;
    if (bad_per() != 0 || per_q.size() != 3 * W - 1) begin
      n_fail++; $display("FAIL inflight_period: bad %0d of %0d want 0 of %0d", bad_per(), per_q.size(), 3 * W - 1);
    end
    clear_cap();
    pulse_req(3);
    wait_done(frame_budget(3), ok);
    n_tests++;
    if (!ok || hi_q.size() != 3 * W || decode_word(1) !== new1) begin
      n_fail++; $display("FAIL inflight_new: bits %0d led1 %h want %h", hi_q.size(),
                         (hi_q.size() >= 2 * W) ? decode_word(1) : '0, new1);
    end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [W-1:0] model_scale(input logic [W-1:0] w, input int br);
    logic [W-1:0] r = '0;
    for (int b = 0; b < BPL; b++) r[b*8 +: 8] = 8'((int'(w[b*8 +: 8]) * (br + 1)) / 256);
    return r;
  endfunction

  task automatic test_brightness();
    logic [W-1:0] ff = '1;
    logic [W-1:0] half = {BPL{8'h7F}};
    logic [W-1:0] rw, got;
    int brs[3];
    bit ok;
    write_led(0, ff);
    rw = W'({$urandom, $urandom});
    write_led(1, rw);
    brs = '{127, 255, int'($urandom_range(0, 254))};
    foreach (brs[k]) begin
      bright = 8'(brs[k]);
      clear_cap();
      pulse_req(2);
      wait_done(frame_budget(2), ok);
      got = (hi_q.size() == 2 * W) ? decode_word(0) : '0;
      n_tests++;
      if (!ok || got !== ((brs[k] == 127) ? half : model_scale(ff, brs[k]))) begin
        n_fail++; $display("FAIL bright_ff br=%0d: got %h want %h", brs[k], got, model_scale(ff, brs[k]));
      end
      got = (hi_q.size() == 2 * W) ? decode_word(1) : '0;
      n_tests++;
      if (got !== model_scale(rw, brs[k]) || bad_per() != 0) begin
        n_fail++; $display("FAIL bright_rand br=%0d: got %h want %h bad_per %0d", brs[k], got, model_scale(rw, brs[k]), bad_per());
      end
    end
    bright = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random_frames();
    test_back_to_back();
    test_request_at_done();
    test_reset_mid();
    test_write_in_flight();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Parametrised WS2812/SK6812 serial LED frame controller; single clock domain (clk100) for both the LED colour table and the serialiser.
- Holds LED_NUM colour words in internal single-clock dual-port RAM.
- On request, streams a runtime-selectable number of words, MSB first, on one pin, then the latch (reset) code.
- Generalises width (RGB/RGBW), bit timing, frame length, and queues a request raised mid-frame.

Parameters:
- LED_NUM, 16: table depth, in LEDs.
- BYTES_PER_LED, 3: 3 = GRB (24-bit words), 4 = GRBW (32-bit words); other values are an elaboration error.
- T0H, 40: high cycles for a 0 bit (400 ns at 100 MHz).
- T1H, 80: high cycles for a 1 bit.
- TBIT, 125: total cycles per bit; must satisfy T0H < T1H < TBIT.
- TRST, 8000: low cycles of the latch code (80 us).
- ADDR_BIT, $clog2(LED_NUM): table address width (derived).
- W, 8*BYTES_PER_LED: word width (derived).

Ports:
- clk100, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- wr_en, in, 1: table write strobe.
- wr_addr, in, ADDR_BIT: table write address.
- wr_data, in, W: colour word; first-transmitted byte in the MSBs.
- frame_len, in, ADDR_BIT+1: LEDs to send; sampled on request acceptance.
- update_request, in, 1: one-cycle pulse starts a frame.
- busy, out, 1: high from acceptance until update_done.
- update_done, out, 1: one-cycle pulse after the latch code completes.
- DOUT, out, 1: serial LED data.
- RST, out, 1: high while the latch code is driven; the preferred window for table updates.

Behaviour:
- Reset: DOUT=0, RST=0, busy=0, update_done=0, pending=0, FSM=IDLE. Table contents are not reset.
- Table writes:
  - Accepted every cycle that wr_en=1, in any state; wr_addr >= LED_NUM is dropped.
  - Read latency is 1 cycle; a same-address read/write returns the old data.
- FSM states: IDLE, FETCH, WAIT_Q, BIT_HI, BIT_LO, LATCH, DONE.
- IDLE:
  - Enter FETCH when update_request or pending is set. Set busy and clear pending.
  - On entry, latch len = min(frame_len, LED_NUM) and set idx=0.
  - If len=0, go straight to LATCH.
- FETCH: drive read address idx, then go to WAIT_Q.
- WAIT_Q: load the shift register with q and set bitcnt=W-1, then go to BIT_HI. The word is captured here, so later writes do not affect the LED in flight.
- BIT_HI:
  - DOUT=1 for T0H or T1H cycles, chosen by shreg MSB.
  - The cycle counter spans the whole bit; on reaching the high time, go to BIT_LO.
- BIT_LO:
  - DOUT=0 until TBIT total cycles have elapsed.
  - If bitcnt>0: shift left, decrement bitcnt, go to BIT_HI.
  - Else if idx+1 < len: increment idx, go to FETCH.
  - Else go to LATCH.
- Inter-word gap: FETCH plus WAIT_Q add exactly 2 low cycles. Compensate by shortening the last BIT_LO of each non-final word by 2 cycles, so the bit period stays exactly TBIT throughout the frame.
- LATCH: DOUT=0 and RST=1 for TRST cycles, then go to DONE.
- DONE: assert update_done for 1 cycle, clear busy, go to IDLE.
- update_request while busy: sets pending (a single-depth queue; further pulses merge). A request in the same cycle as DONE also sets pending, so it is never lost.
- Reset asserted mid-frame: DOUT drops to 0 asynchronously and every state variable clears. The partial frame is abandoned with no update_done.
- Counter width: $clog2(max(TRST,TBIT)+1). idx wraps only via the len compare, never past LED_NUM-1.

Optional Feature:
- Macro: WS2812_BRIGHTNESS_EN.
- Defined:
  - Adds input port bright[7:0], sampled on request acceptance.
  - Each byte is scaled as (byte*(bright+1))>>8 in WAIT_Q, adding 1 register stage, so WAIT_Q lasts 2 cycles and the gap compensation becomes 3.
  - bright=255 is bit-identical to the feature-off output.
- Undefined: no port and no multiplier; bytes are sent raw.

Decomposition:
- Package ws2812_pkg:
  - FSM state enum.
  - Default timing constants for 100 MHz (T0H/T1H/TBIT/TRST).
  - Function for the counter width.
  - Byte-order constants (GRB/GRBW).
- Sub-module ws2812_tdp_ram: parametrised single-clock RAM (depth LED_NUM, width W), registered read, read-old-data on collision.

Test Plan:
- Write word 0 = 24'hA5_0F_F0, frame_len=1, pulse request:
  - DOUT bit 23 high for 80 cycles then low for 45; bit 22 high for 40 cycles.
  - 24 bits total, then RST high for 8000 cycles, then update_done 1 cycle later.
- frame_len=20 with LED_NUM=16: exactly 16*24 bits are sent. frame_len=0: only the latch code is sent, and update_done still fires.
- Pulse request during bit 5 of LED 2: one extra frame starts right after update_done; with 3 pulses, still only one extra frame.
- Assert reset_n=0 mid-BIT_HI: DOUT=0 in the same cycle; busy=0 and no update_done; the next request sends a clean frame.
- Write LED 1 while LED 1 is being shifted: the old value goes out; the next frame carries the new value. Inter-word bit period measures exactly 125 cycles.
- BYTES_PER_LED=4 with WS2812_BRIGHTNESS_EN, bright=127, byte 8'hFF: byte sent as 8'h7F; bright=255 gives 8'hFF.
